// File: rtl/item_map_gen.sv
// rtl/item_map_gen.sv - LFSR-driven non-overlapping item placement with per-slot move channels
// Purpose: places up to MAX_ITEMS items on distinct GRID_X x GRID_Y cells using a 16-bit
//   Galois LFSR, tags each slot with its kind, then applies moves from NUM_MOVE channels.
// Ports:
//   clock, reset              - clock, synchronous active-high reset
//   start, quantity           - begin generation (IDLE only), items requested (clipped to MAX_ITEMS)
//   busy, done, fail, count   - generation status; fail is sticky until the next start
//   data                      - flat item list, entry n at data[n*32 +: 32]
//   move_en/index/dx/dy/moved/visible - per-channel move requests, serviced in IDLE only
// Optional: define ITEM_MAP_CLAMP_EN to saturate moved positions to the grid instead of wrapping.
module item_map_gen #(
  parameter int          MAX_ITEMS = 32,
  parameter int          NUM_MOVE  = 2,
  parameter int          GRID_X    = 20,
  parameter int          GRID_Y    = 10,
  parameter int          CELL_W    = 512,
  parameter int          CELL_H    = 512,
  parameter int          GOLD_N    = 8,
  parameter int          STONE_N   = 8,
  parameter int          MAX_RETRY = 63,
  parameter logic [15:0] SEED      = 16'h00A3,
  localparam int         IDX_W     = $clog2(MAX_ITEMS)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      start,
  input  logic [IDX_W:0]            quantity,
  output logic                      busy,
  output logic                      done,
  output logic                      fail,
  output logic [IDX_W:0]            count,
  output logic [MAX_ITEMS*32-1:0]   data,
  input  logic [NUM_MOVE-1:0]       move_en,
  input  logic [NUM_MOVE*IDX_W-1:0] move_index,
  input  logic [NUM_MOVE*11-1:0]    move_dx,
  input  logic [NUM_MOVE*11-1:0]    move_dy,
  input  logic [NUM_MOVE-1:0]       move_moved,
  input  logic [NUM_MOVE-1:0]       move_visible
);

  localparam int          CELLS    = GRID_X * GRID_Y;
  localparam int          CIDX_W   = (CELLS > 1) ? $clog2(CELLS) : 1;
  localparam int          RTY_W    = $clog2(MAX_RETRY + 1);
  localparam int          X_MAX    = (GRID_X - 1) * CELL_W;
  localparam int          Y_MAX    = (GRID_Y - 1) * CELL_H;
  localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_DRAW, S_CHECK, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [15:0]        lfsr_q, lfsr_d;
  logic [7:0]         cx_q, cx_d, cy_q, cy_d;
  logic [CELLS-1:0]   occ_q, occ_d;
  logic [IDX_W:0]     count_q, count_d, qty_q, qty_d;
  logic [RTY_W-1:0]   retry_q, retry_d;
  logic               fail_q, fail_d;
  logic [31:0]        data_q [MAX_ITEMS];
  logic [31:0]        data_d [MAX_ITEMS];

  logic [15:0]        lfsr_next;
  logic [IDX_W:0]     qty_eff;
  logic [CIDX_W-1:0]  cell_idx;
  logic [12:0]        px;
  logic [11:0]        py;
  logic [1:0]         kind;
  logic signed [31:0] mv_sx, mv_sy, mv_nx, mv_ny;
  logic               mv_hit, mv_vis, mv_mov;

  // Galois step: shift right, fold the taps back in when a one falls out.
  assign lfsr_next = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
  assign qty_eff   = (quantity > (IDX_W+1)'(MAX_ITEMS)) ? (IDX_W+1)'(MAX_ITEMS) : quantity;
  assign cell_idx  = CIDX_W'(int'(cy_q) * GRID_X + int'(cx_q));
  assign px        = 13'(int'(cx_q) * CELL_W);
  assign py        = 12'(int'(cy_q) * CELL_H);

  always_comb begin
    kind = 2'd2;
    if (int'(count_q) < GOLD_N)                kind = 2'd0;
    else if (int'(count_q) < GOLD_N + STONE_N) kind = 2'd1;
  end

  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    occ_d   = occ_q;
    count_d = count_q;
    qty_d   = qty_q;
    retry_d = retry_q;
    fail_d  = fail_q;
    data_d  = data_q;
    mv_sx   = '0;
    mv_sy   = '0;
    mv_nx   = '0;
    mv_ny   = '0;
    mv_hit  = 1'b0;
    mv_vis  = 1'b0;
    mv_mov  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_CLEAR;
        end else begin
          for (int i = 0; i < MAX_ITEMS; i++) begin
            mv_sx  = '0;
            mv_sy  = '0;
            mv_hit = 1'b0;
            mv_vis = 1'b0;
            mv_mov = 1'b0;
            // Walk channels high to low so the lowest-numbered channel's flags land last.
            for (int c = NUM_MOVE - 1; c >= 0; c--) begin
              if (move_en[c] && move_index[c*IDX_W +: IDX_W] == IDX_W'(i) &&
                  {1'b0, move_index[c*IDX_W +: IDX_W]} < count_q) begin
                mv_sx  = mv_sx + {{21{move_dx[c*11+10]}}, move_dx[c*11 +: 11]};
                mv_sy  = mv_sy + {{21{move_dy[c*11+10]}}, move_dy[c*11 +: 11]};
                mv_hit = 1'b1;
                mv_vis = move_visible[c];
                mv_mov = move_moved[c];
              end
            end
            mv_nx = $signed({19'b0, data_q[i][31:19]}) + mv_sx;
            mv_ny = $signed({20'b0, data_q[i][18:7]}) + mv_sy;
`ifdef ITEM_MAP_CLAMP_EN
            if (mv_nx < 0)          mv_nx = '0;
            else if (mv_nx > X_MAX) mv_nx = X_MAX;
            if (mv_ny < 0)          mv_ny = '0;
            else if (mv_ny > Y_MAX) mv_ny = Y_MAX;
`endif
            if (mv_hit) data_d[i] = {mv_nx[12:0], mv_ny[11:0], data_q[i][6:2], mv_vis, mv_mov};
          end
        end
      end
      S_CLEAR: begin
        for (int i = 0; i < MAX_ITEMS; i++) data_d[i] = '0;
        occ_d   = '0;
        count_d = '0;
        retry_d = '0;
        fail_d  = 1'b0;
        qty_d   = qty_eff;
        state_d = (qty_eff == '0) ? S_DONE : S_DRAW;
      end
      S_DRAW: begin
        lfsr_d  = lfsr_next;
        cx_d    = 8'(lfsr_next[15:8] % GRID_X);
        cy_d    = 8'(lfsr_next[7:0] % GRID_Y);
        state_d = S_CHECK;
      end
      S_CHECK: begin
        if (!occ_q[cell_idx]) begin
          data_d[count_q[IDX_W-1:0]] = {px, py, kind, 3'b000, 1'b1, 1'b0};
          occ_d[cell_idx] = 1'b1;
          count_d = count_q + 1'b1;
          retry_d = '0;
          state_d = (count_q + 1'b1 == qty_q) ? S_DONE : S_DRAW;
        end else begin
          retry_d = retry_q + 1'b1;
          if (int'(retry_q) + 1 == MAX_RETRY) begin
            fail_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_DRAW;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      lfsr_q  <= SEED_EFF;
      cx_q    <= '0;
      cy_q    <= '0;
      occ_q   <= '0;
      count_q <= '0;
      qty_q   <= '0;
      retry_q <= '0;
      fail_q  <= 1'b0;
      for (int i = 0; i < MAX_ITEMS; i++) data_q[i] <= '0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      occ_q   <= occ_d;
      count_q <= count_d;
      qty_q   <= qty_d;
      retry_q <= retry_d;
      fail_q  <= fail_d;
      for (int i = 0; i < MAX_ITEMS; i++) data_q[i] <= data_d[i];
    end
  end

  assign busy  = (state_q == S_CLEAR) || (state_q == S_DRAW) || (state_q == S_CHECK);
  assign done  = (state_q == S_DONE);
  assign fail  = fail_q;
  assign count = count_q;

  always_comb begin
    data = '0;
    for (int i = 0; i < MAX_ITEMS; i++) data[i*32 +: 32] = data_q[i];
  end

endmodule
